// File: rtl/crypto1_pkg.sv
// Shared Crypto1 definitions: state bit order, LFSR taps, step functions,
// filter function and the FSM state type used by the keystream block.
//
// State bit order: state[47] holds x0 (the oldest bit), state[0] holds x47
// (the newest bit). A forward step shifts left and inserts the feedback bit
// at state[0].
package crypto1_pkg;

    // Feedback taps x0,x5,x9,x10,x12,x14,x15,x17,x19,x24,x25,x27,x29,x35,
    // x39,x41,x42,x43 mapped to state[47-i].
    localparam logic [47:0] LFSR_TAPS = 48'h846b_50d4_1170;

    // Filter truth tables, indexed with the first listed input as MSB.
    localparam logic [15:0] FA_TABLE = 16'hd938;
    localparam logic [15:0] FB_TABLE = 16'hf22c;
    localparam logic [31:0] FC_TABLE = 32'hec57_e80a;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } c1_state_e;

    // One forward LFSR step without input injection.
    function automatic logic [47:0] lfsr_step_fwd(input logic [47:0] s);
        return {s[46:0], ^(s & LFSR_TAPS)};
    endfunction

    // Exact inverse of lfsr_step_fwd: recover the bit that fell off the top.
    function automatic logic [47:0] lfsr_step_bwd(input logic [47:0] s);
        logic [46:0] low_s;
        logic        msb_s;
        low_s = s[47:1];
        msb_s = s[0] ^ (^(low_s & LFSR_TAPS[46:0]));
        return {msb_s, low_s};
    endfunction

    // Nonlinear filter over the odd-indexed bits x9, x11, ..., x47.
    function automatic logic crypto1_filter(input logic [47:0] s);
        logic [3:0] g0_s;
        logic [3:0] g1_s;
        logic [3:0] g2_s;
        logic [3:0] g3_s;
        logic [3:0] g4_s;
        logic [4:0] z_s;
        g0_s = {s[38], s[36], s[34], s[32]};   // x9  x11 x13 x15
        g1_s = {s[30], s[28], s[26], s[24]};   // x17 x19 x21 x23
        g2_s = {s[22], s[20], s[18], s[16]};   // x25 x27 x29 x31
        g3_s = {s[14], s[12], s[10], s[8]};    // x33 x35 x37 x39
        g4_s = {s[6],  s[4],  s[2],  s[0]};    // x41 x43 x45 x47
        z_s[0] = FA_TABLE[g0_s];
        z_s[1] = FB_TABLE[g1_s];
        z_s[2] = FB_TABLE[g2_s];
        z_s[3] = FA_TABLE[g3_s];
        z_s[4] = FB_TABLE[g4_s];
        return FC_TABLE[z_s];
    endfunction

endpackage

// File: rtl/crypto1_keystream.sv
// Crypto1 keystream / rollback engine: loads a 48-bit LFSR state, runs a
// bounded number of forward steps (collecting filter bits) or backward steps,
// then pulses DONE with the final state and collected stream.
module crypto1_keystream
    import crypto1_pkg::*;
#(
    parameter int MAX_LEN = 64
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               MODE,
    input  logic [47:0]        KEY,
    input  logic [6:0]         COUNT,
    output logic               BUSY,
    output logic               DONE,
    output logic [47:0]        STATE_OUT,
    output logic [MAX_LEN-1:0] STREAM
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_LEN);

    c1_state_e          state_q, state_d;
    logic               mode_q, mode_d;
    logic [6:0]         count_q, count_d;
    logic [6:0]         step_q, step_d;
    logic [47:0]        lfsr_q, lfsr_d;
    logic [MAX_LEN-1:0] stream_q, stream_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [6:0]         count_clamped_s;

    // Requested step counts beyond the stream width saturate at MAX_LEN.
    always_comb begin
        if (COUNT > MAX_CNT) begin
            count_clamped_s = MAX_CNT;
        end else begin
            count_clamped_s = COUNT;
        end
    end

    // Next-state logic for the FSM, LFSR, stream register and step counter.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        count_d  = count_q;
        step_d   = step_q;
        lfsr_d   = lfsr_q;
        stream_d = stream_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d  = ST_RUN;
                    lfsr_d   = KEY;
                    mode_d   = MODE;
                    count_d  = count_clamped_s;
                    step_d   = 7'd0;
                    stream_d = {MAX_LEN{1'b0}};
                    busy_d   = 1'b1;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (step_q == count_q) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                    step_d  = step_q + 7'd1;
                    if (mode_q) begin
                        lfsr_d = lfsr_step_bwd(lfsr_q);
                    end else begin
                        // Filter bit comes from the state before this step.
                        stream_d = {stream_q[MAX_LEN-2:0], crypto1_filter(lfsr_q)};
                        lfsr_d   = lfsr_step_fwd(lfsr_q);
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            count_q  <= 7'd0;
            step_q   <= 7'd0;
            lfsr_q   <= 48'd0;
            stream_q <= {MAX_LEN{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            step_q   <= step_d;
            lfsr_q   <= lfsr_d;
            stream_q <= stream_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign STATE_OUT = lfsr_q;
    assign STREAM    = stream_q;

endmodule
